delay_gen_multi: RTL and testbench

- Parametrised, multi-channel successor of the single-shot power-on delay generator.
- Each channel is an independent counter-based timer with a runtime-programmable delay, one-shot or periodic mode, and start/stop/restart control.
- Channels with AUTO_START set reproduce the fixed power-on behaviour: they assert delayed_o a fixed number of cycles after reset release.
- Used for reset sequencing, power-up settling waits and periodic housekeeping ticks inside CRG.

---
 rtl/crg_delay_pkg.sv | 6 +
 rtl/delay_gen_ch.sv | 50 +++++
 rtl/delay_gen_multi.sv | 35 +++
 tb/tb_delay_gen_multi.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/crg_delay_pkg.sv
// crg_delay_pkg: shared state encoding and mode constants for the CRG delay timers
package crg_delay_pkg;
  typedef enum logic [1:0] {DLY_IDLE, DLY_RUN, DLY_DONE} dly_state_e;
  localparam logic DLY_ONESHOT  = 1'b0;
  localparam logic DLY_PERIODIC = 1'b1;
endpackage

// File: rtl/delay_gen_ch.sv
// delay_gen_ch: one programmable one-shot/periodic delay timer channel
module delay_gen_ch
  import crg_delay_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int RST_DLY = 128,
  parameter bit AUTO_EN = 1'b0
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_delay,
  output logic             o_busy,
  output logic             o_tick,
  output logic             o_delayed
);
  dly_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_dly;
  logic             r_mode;
  logic             w_exp;
  assign w_exp     = (r_state == DLY_RUN) && (r_cnt == r_dly - CNT_W'(1));
  assign o_busy    = r_state == DLY_RUN;
  assign o_tick    = w_exp;
  assign o_delayed = w_exp || (r_state == DLY_DONE);
  // stop beats start, start beats expiry so a restart on the tick cycle skips DONE
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= AUTO_EN ? DLY_RUN : DLY_IDLE;
      r_cnt   <= '0;
      r_dly   <= AUTO_EN ? CNT_W'(RST_DLY) : CNT_W'(1);
      r_mode  <= DLY_ONESHOT;
    end else if (i_stop) begin
      r_state <= DLY_IDLE;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_state <= DLY_RUN;
      r_cnt   <= '0;
      r_dly   <= (i_delay == '0) ? CNT_W'(1) : i_delay;
      r_mode  <= i_mode;
    end else if (w_exp) begin
      r_cnt   <= '0;
      r_state <= (r_mode == DLY_PERIODIC) ? DLY_RUN : DLY_DONE;
    end else if (r_state == DLY_RUN) begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/delay_gen_multi.sv
// delay_gen_multi: NUM_CH independent delay timers; AUTO_START channels fire RST_DLY cycles after reset
module delay_gen_multi #(
  parameter int                NUM_CH     = 4,
  parameter int                CNT_W      = 16,
  parameter int                RST_DLY    = 128,
  parameter logic [NUM_CH-1:0] AUTO_START = NUM_CH'(1)
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  input  logic [NUM_CH-1:0]       start_i,
  input  logic [NUM_CH-1:0]       stop_i,
  input  logic [NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH*CNT_W-1:0] delay_i,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       delayed_o
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    delay_gen_ch #(
      .CNT_W  (CNT_W),
      .RST_DLY(RST_DLY),
      .AUTO_EN(AUTO_START[g])
    ) u_ch (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .i_start  (start_i[g]),
      .i_stop   (stop_i[g]),
      .i_mode   (mode_i[g]),
      .i_delay  (delay_i[g*CNT_W +: CNT_W]),
      .o_busy   (busy_o[g]),
      .o_tick   (tick_o[g]),
      .o_delayed(delayed_o[g])
    );
  end
endmodule

// File: tb/tb_delay_gen_multi.sv
// tb_delay_gen_multi: random and directed stimulus against an elapsed-time reference model
module tb_delay_gen_multi;
  localparam int N = 4, W = 16, RD = 128;
  localparam logic [N-1:0] AS = 4'b0001;
  logic clk_i = 1'b0;
  logic arst_n_i;
  logic [N-1:0] start_i, stop_i, mode_i, busy_o, tick_o, delayed_o;
  logic [N*W-1:0] delay_i;
  int n_cmp = 0, n_bad = 0, t;
  bit run[N], per[N];
  int t0[N], d[N];
  always #5 clk_i = ~clk_i;
  delay_gen_multi #(.NUM_CH(N), .CNT_W(W), .RST_DLY(RD), .AUTO_START(AS)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .start_i(start_i), .stop_i(stop_i),
    .mode_i(mode_i), .delay_i(delay_i), .busy_o(busy_o), .tick_o(tick_o),
    .delayed_o(delayed_o)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h want %0h", tag, t, act, exp);
    end
  endtask
  task automatic model_reset();
    t = 1;
    for (int i = 0; i < N; i++) begin
      run[i] = AS[i];
      per[i] = 1'b0;
      t0[i]  = 0;
      d[i]   = RD;
    end
  endtask
  // expected outputs from elapsed cycles since the last accepted start
  task automatic exp_out(output logic [N-1:0] b, output logic [N-1:0] k, output logic [N-1:0] y);
    for (int i = 0; i < N; i++) begin
      int el;
      el   = t - t0[i];
      k[i] = run[i] && (per[i] ? (el % d[i] == 0) : (el == d[i]));
      b[i] = run[i] && (per[i] || el <= d[i]);
      y[i] = k[i] || (run[i] && !per[i] && el > d[i]);
    end
  endtask
  task automatic cyc(input logic [N-1:0] st, input logic [N-1:0] sp,
                     input logic [N-1:0] md, input logic [N*W-1:0] dl);
    logic [N-1:0] eb, ek, ey;
    exp_out(eb, ek, ey);
    chk("busy", busy_o, eb);
    chk("tick", tick_o, ek);
    chk("delayed", delayed_o, ey);
    start_i = st; stop_i = sp; mode_i = md; delay_i = dl;
    @(posedge clk_i);
    for (int i = 0; i < N; i++) begin
      if (sp[i]) run[i] = 1'b0;
      else if (st[i]) begin
        run[i] = 1'b1;
        t0[i]  = t;
        d[i]   = (dl[i*W +: W] == 0) ? 1 : int'(dl[i*W +: W]);
        per[i] = md[i];
      end
    end
    #1;
    t++;
    start_i = '0; stop_i = '0; mode_i = '0; delay_i = '0;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc('0, '0, '0, '0);
  endtask
  function automatic logic [N*W-1:0] dly1(input int ch, input int v);
    logic [N*W-1:0] r;
    r = '0;
    r[ch*W +: W] = W'(v);
    return r;
  endfunction
  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy_o, AS);
    chk({tag, "_tick"}, tick_o, 0);
    chk({tag, "_delayed"}, delayed_o, 0);
  endtask
  initial begin
    int c, k;
    logic [N-1:0] st, sp, md;
    logic [N*W-1:0] dl;
    arst_n_i = 1'b0; start_i = '0; stop_i = '0; mode_i = '0; delay_i = '0;
    t = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset("rst");
    arst_n_i = 1'b1;
    model_reset();
    while (t < RD) idle(1);
    chk("auto_tick", tick_o[0], 1);
    chk("auto_delayed", delayed_o[0], 1);
    idle(5);
    chk("auto_hold", delayed_o, 4'b0001);
    c = t;
    cyc(4'b0010, '0, '0, dly1(1, 5));
    idle(4);
    chk("d5_tick", tick_o[1], 1);
    idle(3);
    cyc('0, 4'b0010, '0, '0);
    idle(2);
    cyc(4'b0100, '0, 4'b0100, dly1(2, 3));
    idle(6);
    cyc('0, 4'b0100, '0, '0);
    idle(4);
    c = t;
    cyc(4'b1000, '0, '0, dly1(3, 8));
    idle(3);
    cyc(4'b1000, '0, '0, dly1(3, 10));
    idle(9);
    chk("restart_tick", t - c, 14);
    chk("restart_tick_hi", tick_o[3], 1);
    cyc('0, 4'b1000, '0, '0);
    cyc(4'b0010, '0, '0, dly1(1, 0));
    chk("d0_tick", tick_o[1], 1);
    idle(3);
    cyc(4'b0100, 4'b0100, '0, dly1(2, 4));
    chk("ss_busy", busy_o[2], 0);
    idle(6);
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        st[i] = ($urandom % 8) == 0;
        sp[i] = ($urandom % 24) == 0;
        md[i] = $urandom % 2;
        dl[i*W +: W] = W'($urandom_range(0, 12));
      end
      cyc(st, sp, md, dl);
    end
    cyc(4'b1110, '0, 4'b0100, {W'(20), W'(20), W'(20), W'(0)});
    idle(7);
    #2;
    arst_n_i = 1'b0;
    #1;
    chk_reset("arst");
    @(posedge clk_i);
    #1;
    chk_reset("arst_hold");
    arst_n_i = 1'b1;
    model_reset();
    while (t < RD) idle(1);
    chk("rerun_tick", tick_o[0], 1);
    idle(2);
    c = t;
    cyc(4'b1000, '0, '0, dly1(3, 65535));
    k = 0;
    while (!tick_o[3] && k < 70000) begin
      idle(1);
      k++;
    end
    chk("dmax_tick", t - c, 65535);
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
